// File: rtl/div_by_sub.sv
// Sequential unsigned divider by repeated subtraction: 2W-bit dividend / W-bit divisor.
// Shares the start/rdy handshake of the add-based multiplier; flags divide-by-zero and overflow.
module div_by_sub #(
   parameter int data_width = 8
) (
   input  logic                      clk,
   input  logic                      rst_b,
   input  logic                      start,
   input  logic [2*data_width-1:0]   A,
   input  logic [data_width-1:0]     B,
   output logic                      rdy,
   output logic                      done,
   output logic [data_width-1:0]     Q,
   output logic [data_width-1:0]     R,
   output logic                      dbz,
   output logic                      ovf
);

   localparam int W = data_width;

   typedef enum logic {S_idle, S_sub} state_t;

   state_t           state_reg, state_next;
   logic [2*W-1:0]   rr_reg, rr_next;
   logic [W-1:0]     rb_reg, rb_next;
   logic [W-1:0]     rq_reg, rq_next;
   logic             done_reg, done_next;
   logic             dbz_reg, dbz_next;
   logic             ovf_reg, ovf_next;

   logic [2*W-1:0]   rb_ext;
   logic             rr_lt_rb;
   logic             rq_full;

   assign rb_ext   = {{W{1'b0}}, rb_reg};
   assign rr_lt_rb = (rr_reg < rb_ext);
   assign rq_full  = (rq_reg == {W{1'b1}});

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_reg <= S_idle;
         rr_reg    <= '0;
         rb_reg    <= '0;
         rq_reg    <= '0;
         done_reg  <= 1'b0;
         dbz_reg   <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         rr_reg    <= rr_next;
         rb_reg    <= rb_next;
         rq_reg    <= rq_next;
         done_reg  <= done_next;
         dbz_reg   <= dbz_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      rr_next    = rr_reg;
      rb_next    = rb_reg;
      rq_next    = rq_reg;
      done_next  = 1'b0;
      dbz_next   = dbz_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         S_idle: begin
            if (start) begin
               rr_next  = A;
               rq_next  = '0;
               ovf_next = 1'b0;
               if (B == '0) begin
                  // Zero divisor finishes immediately without leaving idle
                  dbz_next  = 1'b1;
                  done_next = 1'b1;
               end else begin
                  rb_next    = B;
                  dbz_next   = 1'b0;
                  state_next = S_sub;
               end
            end
         end
         S_sub: begin
            if (rr_lt_rb) begin
               state_next = S_idle;
               done_next  = 1'b1;
            end else if (rq_full) begin
               // Another subtract would wrap the quotient; hold RR/RQ and flag it
               ovf_next   = 1'b1;
               done_next  = 1'b1;
               state_next = S_idle;
            end else begin
               rr_next = rr_reg - rb_ext;
               rq_next = rq_reg + 1'b1;
            end
         end
         default: state_next = S_idle;
      endcase
   end

   assign rdy  = (state_reg == S_idle);
   assign done = done_reg;
   assign Q    = rq_reg;
   assign R    = rr_reg[W-1:0];
   assign dbz  = dbz_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_div_by_sub.sv
// Directed bench for div_by_sub (W=8): results, latency, dbz/ovf flags, ignored start and reset abort.
module tb_div_by_sub;

   localparam int W = 8;

   logic           clk;
   logic           rst_b;
   logic           start;
   logic [2*W-1:0] A;
   logic [W-1:0]   B;
   logic           rdy;
   logic           done;
   logic [W-1:0]   Q;
   logic [W-1:0]   R;
   logic           dbz;
   logic           ovf;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   div_by_sub #(.data_width(W)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .start (start),
      .A     (A),
      .B     (B),
      .rdy   (rdy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .dbz   (dbz),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one request; returns after the accepting edge.
   task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b);
      A     = a;
      B     = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      A     = '0;
      B     = '0;
   endtask

   // Counts edges until rdy returns, bounded so a stuck DUT still reaches the summary.
   task automatic wait_rdy(output int cnt);
      cnt = 0;
      while (!rdy && cnt < 600) begin
         cnt++;
         tick();
      end
   endtask

   int cnt;
   int pulses;

   initial begin
      rst_b = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      tick();
      tick();
      chk("reset_rdy", rdy, 1);
      chk("reset_Q", Q, 0);
      chk("reset_R", R, 0);
      chk("reset_done", done, 0);
      chk("reset_dbz", dbz, 0);
      chk("reset_ovf", ovf, 0);
      rst_b = 1'b1;
      tick();

      // 100 / 7 = 14 r 2, busy for 15 cycles
      issue(16'd100, 8'd7);
      chk("t1_busy_after_accept", rdy, 0);
      wait_rdy(cnt);
      chk("t1_latency", cnt, 15);
      chk("t1_Q", Q, 14);
      chk("t1_R", R, 2);
      chk("t1_done", done, 1);
      chk("t1_dbz", dbz, 0);
      chk("t1_ovf", ovf, 0);
      tick();
      chk("t1_done_one_cycle", done, 0);
      chk("t1_Q_hold", Q, 14);

      // 5 / 9 = 0 r 5, one S_sub cycle
      issue(16'd5, 8'd9);
      wait_rdy(cnt);
      chk("t2_latency", cnt, 1);
      chk("t2_Q", Q, 0);
      chk("t2_R", R, 5);
      chk("t2_done", done, 1);

      // Back-to-back start on the done cycle: 20 / 6 = 3 r 2
      issue(16'd20, 8'd6);
      chk("b2b_accepted", rdy, 0);
      wait_rdy(cnt);
      chk("b2b_latency", cnt, 4);
      chk("b2b_Q", Q, 3);
      chk("b2b_R", R, 2);
      tick();

      // Divide by zero stays idle and pulses done next cycle
      issue(16'd1234, 8'd0);
      chk("t3_rdy", rdy, 1);
      chk("t3_done", done, 1);
      chk("t3_dbz", dbz, 1);
      chk("t3_Q", Q, 0);
      tick();
      chk("t3_done_clear", done, 0);
      chk("t3_dbz_hold", dbz, 1);
      issue(16'd10, 8'd3);
      wait_rdy(cnt);
      chk("t3b_latency", cnt, 4);
      chk("t3b_dbz", dbz, 0);
      chk("t3b_Q", Q, 3);
      chk("t3b_R", R, 1);
      tick();

      // 300 / 1 overflows after 256 edges
      issue(16'd300, 8'd1);
      wait_rdy(cnt);
      chk("t4_latency", cnt, 256);
      chk("t4_ovf", ovf, 1);
      chk("t4_Q", Q, 255);
      chk("t4_done", done, 1);
      tick();

      // 65279 / 255 = 255 r 254, largest quotient without overflow
      issue(16'd65279, 8'd255);
      wait_rdy(cnt);
      chk("t4b_latency", cnt, 256);
      chk("t4b_ovf", ovf, 0);
      chk("t4b_Q", Q, 255);
      chk("t4b_R", R, 254);
      chk("t4b_done", done, 1);
      tick();

      // start during S_sub is ignored
      issue(16'd100, 8'd7);
      tick();
      tick();
      A     = 16'd50;
      B     = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_rdy(cnt);
      chk("t5_latency", cnt + 3, 15);
      chk("t5_Q", Q, 14);
      chk("t5_R", R, 2);
      tick();

      // Reset mid-division aborts with no done pulse
      issue(16'd100, 8'd7);
      tick();
      tick();
      tick();
      tick();
      chk("t6_busy_before_reset", rdy, 0);
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      chk("t6_rdy", rdy, 1);
      chk("t6_Q", Q, 0);
      chk("t6_R", R, 0);
      chk("t6_done", done, 0);
      chk("t6_dbz", dbz, 0);
      chk("t6_ovf", ovf, 0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) pulses++;
      end
      chk("t6_no_done_after_reset", pulses, 0);
      chk("t6_still_idle", rdy, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
